dmem_lane_ctrl: RTL
===================

# dmem_lane_ctrl

Parametrised byte-lane data memory with a request/response interface for the CPU load/store path. It splits a `DATA_W` word into `DATA_W/8` independent byte-lane arrays and builds the lane write enables internally from access size and byte offset. Loads are aligned and sign/zero-extended. After every reset it zero-fills the whole memory with an internal sweep and holds off requests until the sweep is done. It sits between the execute/memory stage and on-chip block RAM.

## Interface
Parameters:
- `DATA_W`, 32: word width; must be a power of two and at least 8. `LANES = DATA_W/8`, `OFF_W = log2(LANES)`.
- `WORD_AW`, 10: word-address width. Depth is `2**WORD_AW` words. Byte-address width is `ADDR_W = WORD_AW + OFF_W`.

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `req_valid`  in  1  request present
- `req_ready`  out  1  request accepted when `req_valid & req_ready`
- `req_we`  in  1  1 = store, 0 = load
- `req_addr`  in  `ADDR_W`  byte address
- `req_size`  in  3  log2 of access bytes (0 = byte, 1 = half, 2 = word, …)
- `req_unsigned`  in  1  1 = zero-extend the load, 0 = sign-extend
- `req_wdata`  in  `DATA_W`  store data, LSB-aligned
- `rsp_valid`  out  1  one-cycle response pulse, one per accepted request
- `rsp_rdata`  out  `DATA_W`  load data, LSB-aligned and extended; 0 for stores and errors
- `rsp_err`  out  1  request was misaligned or had an illegal size
- `init_busy`  out  1  zero-fill sweep in progress

## Operation
- Reset values: `req_ready`=0, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `init_busy`=1. The sweep counter is 0.
- States: INIT, then RUN.
  - INIT: write 0 to all lanes at word `cnt`; `cnt` increments every cycle. After `cnt` = `2**WORD_AW - 1` is written, go to RUN. `req_ready` is 0 throughout INIT.
  - RUN: `req_ready` = 1 every cycle. There is no response backpressure.
- Decode on accept:
  - Word index = `req_addr[ADDR_W-1:OFF_W]`; offset `off` = `req_addr[OFF_W-1:0]`; `n = 1 << req_size`.
  - Error if `req_size > OFF_W`, or if `off` is not a multiple of `n`. On error: no array write, `rsp_err`=1, `rsp_rdata`=0.
- Store: lane `i` is written iff `off <= i < off+n`. Lane `i` takes byte `i-off` of `req_wdata`; all other lanes are untouched. The response has `rsp_err`=0 and `rsp_rdata`=0.
- Load: all lanes are read. Bytes `off..off+n-1` are shifted down to bit 0. Upper bits take bit `8n-1` when `req_unsigned`=0, and are 0 otherwise. A full-width load is unextended.
- Hazards:
  - A store accepted in cycle k, followed by a load of the same word in cycle k+1, returns the new data.
  - Only one request is accepted per cycle, so no same-cycle read/write conflict exists.
- Reset asserted mid-operation: in-flight responses are discarded (no `rsp_valid`), and the sweep restarts from word 0.

## Timing
- Without `DMEM_OUTREG_EN`: request accepted at edge k → `rsp_valid` high in the cycle after edge k+1 (latency 1).
- With `DMEM_OUTREG_EN`: latency 2. Behaviour is otherwise identical.
- Full throughput: one request per cycle. Responses return in request order, with a fixed latency.
- INIT lasts exactly `2**WORD_AW` cycles after `rst` deasserts. `req_ready` rises on the following edge.
- Error responses have the same latency as normal responses.

## Configuration
- Macro: `DMEM_OUTREG_EN`.
- Defined: extra pipeline register after the lane mux and extend logic. Read latency is 2 and the path from array output to logic is cut.
- Undefined: alignment and extension are combinational on the array output into a single response register. Read latency is 1.

## Test plan
- Reset/init: `DATA_W`=32, `WORD_AW`=4. Release `rst` → `init_busy` high for 16 cycles, then `req_ready`=1. A load of every word returns 0x00000000.
- Word store then byte loads: store 0x8899AABB to addr 0x8. Load byte 0x8 signed → 0xFFFFFFBB. Load byte 0xB unsigned → 0x00000088. Load half 0xA signed → 0xFFFF8899.
- Partial store masking: word 0x0 = 0x11223344. Store half 0xBEEF at 0x2 → word load returns 0xBEEF3344. Store byte 0x5A at 0x1 → 0xBEEF5A44.
- Misaligned/illegal: load half at 0x3 → `rsp_err`=1, `rsp_rdata`=0, memory unchanged. Store with `req_size`=3 → `rsp_err`=1, no lanes written.
- Back-to-back: store 0xCAFEF00D to 0x4 in cycle k, load 0x4 in cycle k+1 → returns 0xCAFEF00D. `rsp_valid` is high for two consecutive cycles. Check latency 1 and 2 per macro.
- Reset mid-stream: assert `rst` with two loads in flight → no `rsp_valid` appears. The sweep reruns and previously written data reads back 0.

Source files
------------

// File: rtl/dmem_lane_if.sv
// Request/response bus for the byte-lane data memory: the CPU side is master,
// the memory controller is slave.
interface dmem_lane_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [2:0]        req_size;
  logic              req_unsigned;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              init_busy;

  modport master (
    output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, init_busy
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, init_busy
  );
endinterface

// File: rtl/dmem_lane_ctrl.sv
// Byte-lane data memory with zero-fill sweep after reset, aligned/extended loads.
// DMEM_OUTREG_EN adds a register after lane mux/extend (read latency 2 instead of 1).

module dmem_lane_bank #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wrIdx,
  input  logic [AW-1:0] rdIdx,
  input  logic [7:0]    wd,
  output logic [7:0]    rd
);
  logic [7:0] mem [2**AW];

  // Read-first synchronous RAM; a load one cycle after a store sees the new byte.
  always_ff @(posedge clk) begin
    if (we) mem[wrIdx] <= wd;
    rd <= mem[rdIdx];
  end
endmodule

module dmem_lane_ctrl #(
  parameter int DATA_W  = 32,
  parameter int WORD_AW = 10
) (
  input logic        clk,
  input logic        rst,
  dmem_lane_if.slave bus
);
  localparam int LANES  = DATA_W / 8;
  localparam int OFF_W  = $clog2(LANES);
  localparam int ADDR_W = WORD_AW + OFF_W;
`ifdef DMEM_OUTREG_EN
  localparam int STAGES = 2;
`else
  localparam int STAGES = 1;
`endif

  typedef enum logic {INIT, RUN} stateT;

  typedef struct packed {
    logic             isLoad;
    logic             err;
    logic             uns;
    logic [2:0]       size;
    logic [OFF_W-1:0] off;
  } metaT;

  stateT              state, stateNext;
  logic [WORD_AW-1:0] cnt, cntNext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    case (state)
      INIT: begin
        cntNext = cnt + WORD_AW'(1);
        if (&cnt) stateNext = RUN;
      end
      RUN: ;
      default: stateNext = INIT;
    endcase
  end

  assign bus.req_ready = (state == RUN);
  assign bus.init_busy = (state == INIT);

  // Request decode
  logic                  accept;
  logic [WORD_AW-1:0]    wordIdx;
  logic [OFF_W-1:0]      off, offMask;
  logic                  sizeOk, reqErr;
  logic [DATA_W-1:0]     wShift;

  assign accept  = bus.req_valid & bus.req_ready;
  assign wordIdx = bus.req_addr[ADDR_W-1:OFF_W];
  assign off     = bus.req_addr[OFF_W-1:0];
  assign sizeOk  = (bus.req_size <= 3'(OFF_W));
  assign wShift  = bus.req_wdata << {off, 3'b000};

  always_comb begin
    offMask = '0;
    for (int i = 0; i < OFF_W; i++) offMask[i] = (i < int'(bus.req_size));
  end

  assign reqErr = !sizeOk || (|(off & offMask));

  // Lane write ports: the sweep owns them during INIT
  logic [LANES-1:0]        laneWe;
  logic [LANES-1:0][7:0]   laneWd;
  logic [LANES-1:0][7:0]   laneRd;
  logic [WORD_AW-1:0]      wrIdx;

  always_comb begin
    wrIdx  = wordIdx;
    laneWe = '0;
    laneWd = '0;
    if (state == INIT) begin
      wrIdx  = cnt;
      laneWe = '1;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        laneWe[i] = accept && bus.req_we && !reqErr &&
                    (i >= int'(off)) && (i < int'(off) + (1 << bus.req_size));
        laneWd[i] = wShift[8*i +: 8];
      end
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : gLane
    dmem_lane_bank #(.AW(WORD_AW)) uBank (
      .clk  (clk),
      .we   (laneWe[g]),
      .wrIdx(wrIdx),
      .rdIdx(wordIdx),
      .wd   (laneWd[g]),
      .rd   (laneRd[g])
    );
  end

  // Stage 1: request attributes travel alongside the RAM read
  metaT             meta;
  logic [STAGES:0]  vldPipe;

  always_ff @(posedge clk) begin
    meta.isLoad <= !bus.req_we;
    meta.err    <= reqErr;
    meta.uns    <= bus.req_unsigned;
    meta.size   <= bus.req_size;
    meta.off    <= off;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) vldPipe <= '0;
    else     vldPipe <= {vldPipe[STAGES-1:0], accept};
  end

  // Lane mux and extension
  logic [DATA_W-1:0] shifted, ext, loadData;
  logic              signBit;

  assign shifted = laneRd >> {meta.off, 3'b000};

  always_comb begin
    signBit = 1'b0;
    for (int s = 0; s <= OFF_W; s++)
      if (meta.size == 3'(s)) signBit = shifted[(8 << s) - 1];
    ext = '0;
    for (int b = 0; b < DATA_W; b++)
      ext[b] = (b < (8 << meta.size)) ? shifted[b] : (!meta.uns && signBit);
    loadData = (meta.isLoad && !meta.err) ? ext : '0;
  end

  logic [DATA_W-1:0] rspData;
  logic              rspErr;

`ifdef DMEM_OUTREG_EN
  logic [DATA_W-1:0] midData;
  logic              midErr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      midData <= '0;
      midErr  <= 1'b0;
      rspData <= '0;
      rspErr  <= 1'b0;
    end else begin
      midData <= loadData;
      midErr  <= meta.err;
      rspData <= midData;
      rspErr  <= midErr;
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rspData <= '0;
      rspErr  <= 1'b0;
    end else begin
      rspData <= loadData;
      rspErr  <= meta.err;
    end
  end
`endif

  assign bus.rsp_valid = vldPipe[STAGES];
  assign bus.rsp_rdata = rspData;
  assign bus.rsp_err   = rspErr;
endmodule
